div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 195 +++++++++++++++++++
 tb/tb_div_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential 32-bit integer divider for the EX stage (DIV, DIVU, REM, REMU).
// Restoring division: one quotient bit per cycle over 32 CALC cycles, then a
// single FIX cycle applies the sign correction and writes the result.
// Divide-by-zero and the signed overflow case skip CALC and go straight to FIX.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE with
// hold low, flush low and a valid divsel. div_ready drops on acceptance and
// rises again in the cycle divres becomes valid (or on flush); decode stalls
// while div_ready is low. hold freezes every register; flush aborts to IDLE
// and leaves divres untouched; Rst overrides everything.
module div_seq (
  input  logic        clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [2:0]  divsel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        hold,
  input  logic        flush,
  output logic        div_ready,
  output logic [31:0] divres,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_REM  = 3'b011;
  localparam logic [2:0] OP_REMU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_cnt;
  logic [31:0] r_quo;      // dividend magnitude shifting out, quotient shifting in
  logic [32:0] r_rem;      // partial remainder
  logic [31:0] r_dvs;      // divisor magnitude
  logic [2:0]  r_op;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_div_ready;
  logic [31:0] r_divres;

  // Operand decode
  logic        w_valid_op;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div0;
  logic        w_ovf;
  logic        w_special;
  logic        w_accept;

  // One restoring step
  logic [32:0] w_shift;
  logic [33:0] w_trial;
  logic        w_fits;

  // Sign correction
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_result;

  assign w_valid_op = (divsel == OP_DIV) || (divsel == OP_DIVU) ||
                      (divsel == OP_REM) || (divsel == OP_REMU);
  assign w_signed   = (divsel == OP_DIV) || (divsel == OP_REM);
  assign w_a_neg    = w_signed & dividend[31];
  assign w_b_neg    = w_signed & divisor[31];
  // Negating 0x80000000 wraps back to 0x80000000, which is the right magnitude.
  assign w_a_mag    = w_a_neg ? (32'd0 - dividend) : dividend;
  assign w_b_mag    = w_b_neg ? (32'd0 - divisor)  : divisor;
  assign w_div0     = (divisor == 32'd0);
  assign w_ovf      = w_signed && (dividend == 32'h8000_0000) &&
                      (divisor == 32'hFFFF_FFFF);
  assign w_special  = w_div0 | w_ovf;
  assign w_accept   = start & w_valid_op & ~flush;

  // r_rem[32] is always 0 between steps, so {r_rem, bit} minus the divisor
  // fits in 34 bits and bit 33 is the borrow.
  assign w_shift    = {r_rem[31:0], r_quo[31]};
  assign w_trial    = {r_rem, r_quo[31]} - {2'b00, r_dvs};
  assign w_fits     = ~w_trial[33];

  assign w_q_fix    = r_qneg ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix    = r_rneg ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
  assign w_result   = ((r_op == OP_DIV) || (r_op == OP_DIVU)) ? w_q_fix : w_r_fix;

  // State register: reset first, then hold freezes, otherwise advance
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else if (!hold) begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush aborts any phase back to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_special ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == 6'd31) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (flush) begin
      w_next = S_IDLE;
    end
  end

  // Datapath: operand latch, restoring steps, sign fix and result register
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_cnt       <= 6'd0;
      r_quo       <= 32'd0;
      r_rem       <= 33'd0;
      r_dvs       <= 32'd0;
      r_op        <= 3'd0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_div_ready <= 1'b1;
      r_divres    <= 32'd0;
    end else if (!hold) begin
      if (flush) begin
        r_div_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_op        <= divsel;
              r_cnt       <= 6'd0;
              r_dvs       <= w_b_mag;
              r_div_ready <= 1'b0;
              if (w_div0) begin
                // Quotient all ones, remainder is the raw dividend.
                r_quo  <= 32'hFFFF_FFFF;
                r_rem  <= {1'b0, dividend};
                r_qneg <= 1'b0;
                r_rneg <= 1'b0;
              end else if (w_ovf) begin
                r_quo  <= 32'h8000_0000;
                r_rem  <= 33'd0;
                r_qneg <= 1'b0;
                r_rneg <= 1'b0;
              end else begin
                r_quo  <= w_a_mag;
                r_rem  <= 33'd0;
                r_qneg <= w_a_neg ^ w_b_neg;
                r_rneg <= w_a_neg;
              end
            end
          end
          S_CALC: begin
            r_quo <= {r_quo[30:0], w_fits};
            r_rem <= w_fits ? w_trial[32:0] : w_shift;
            r_cnt <= r_cnt + 6'd1;
          end
          S_FIX: begin
            r_divres    <= w_result;
            r_div_ready <= 1'b1;
          end
          default: begin
            r_div_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign div_ready   = r_div_ready;
  assign divres      = r_divres;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed corner cases plus randomized operations checked
// against an arithmetic reference model, latency and abort behaviour included.
module tb_div_seq;

  logic        clk;
  logic        Rst;
  logic        start;
  logic [2:0]  divsel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        hold;
  logic        flush;
  logic        div_ready;
  logic [31:0] divres;
  logic        busy;
  logic [1:0]  o_dbg_state;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  localparam logic [2:0] DIV  = 3'b001;
  localparam logic [2:0] DIVU = 3'b010;
  localparam logic [2:0] REM  = 3'b011;
  localparam logic [2:0] REMU = 3'b100;

  div_seq dut (
    .clk        (clk),
    .Rst        (Rst),
    .start      (start),
    .divsel     (divsel),
    .dividend   (dividend),
    .divisor    (divisor),
    .hold       (hold),
    .flush      (flush),
    .div_ready  (div_ready),
    .divres     (divres),
    .busy       (busy),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    bit     is_div;
    is_div = (op == DIV) || (op == DIVU);
    if (b == 32'd0) return is_div ? 32'hFFFF_FFFF : a;
    if ((op == DIV) || (op == REM)) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return is_div ? q[31:0] : r[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (b == 32'd0) return 1'b1;
    return ((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    divsel   = op;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Full operation with optional hold window and an optional start poke while busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold_at, input int hold_len, input int poke_at,
                        input string tag);
    int exp_lat;
    int n;
    bit done;
    exp_q.push_back(ref_div(op, a, b));
    exp_lat = (is_special(op, a, b) ? 1 : 33) + hold_len;
    issue(op, a, b);
    check({tag, "_rdy_low"}, 32'(div_ready), 32'd0);
    n    = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      if (hold_len > 0 && n == hold_at) hold = 1'b1;
      if (hold_len > 0 && n == hold_at + hold_len) hold = 1'b0;
      if (n == poke_at) begin
        start    = 1'b1;
        divsel   = DIVU;
        dividend = $urandom;
        divisor  = 32'd1;
      end
      if (n == poke_at + 1) start = 1'b0;
      @(negedge clk);
      n++;
      if (div_ready) done = 1'b1;
    end
    hold  = 1'b0;
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    last_exp = exp_q.pop_front();
    check({tag, "_result"}, divres, last_exp);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  // Start a normal op, then abort it after 10 CALC steps by Rst or flush.
  task automatic abort_op(input bit use_rst, input string tag);
    issue(DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    check({tag, "_busy_mid"}, 32'(busy), 32'd1);
    if (use_rst) Rst = 1'b1;
    else         flush = 1'b1;
    start = 1'b1;  // same-cycle start must lose to Rst/flush
    @(negedge clk);
    Rst   = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    if (use_rst) last_exp = 32'd0;
    check({tag, "_rdy"}, 32'(div_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_divres"}, divres, last_exp);
  endtask

  // Pulse start in IDLE under a blocking condition; nothing may start.
  task automatic blocked_start(input logic [2:0] op, input bit with_hold,
                               input bit with_flush, input string tag);
    @(negedge clk);
    start    = 1'b1;
    divsel   = op;
    dividend = 32'd55;
    divisor  = 32'd5;
    hold     = with_hold;
    flush    = with_flush;
    @(negedge clk);
    start = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdy"}, 32'(div_ready), 32'd1);
    check({tag, "_divres"}, divres, last_exp);
  endtask

  // Main sequence
  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    Rst      = 1'b1;
    start    = 1'b0;
    divsel   = 3'd0;
    dividend = 32'd0;
    divisor  = 32'd0;
    hold     = 1'b0;
    flush    = 1'b0;
    last_exp = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(div_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_divres", divres, 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'd0);
    Rst = 1'b0;

    run_op(DIVU, 32'd100, 32'd7, 0, 0, -1, "divu_100_7");
    run_op(REMU, 32'd100, 32'd7, 0, 0, -1, "remu_100_7");
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, -1, "div_m7_2");
    run_op(REM, 32'hFFFF_FFF9, 32'd2, 0, 0, -1, "rem_m7_2");
    run_op(DIV, 32'h1234_5678, 32'd0, 0, 0, -1, "div_by0");
    run_op(REMU, 32'h1234_5678, 32'd0, 0, 0, -1, "remu_by0");
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1, "div_ovf");
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1, "rem_ovf");
    run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1, "divu_big");
    run_op(DIV, 32'h8000_0000, 32'd1, 0, 0, -1, "div_min_1");
    run_op(REM, 32'd7, 32'hFFFF_FFFE, 0, 0, -1, "rem_7_m2");
    run_op(DIVU, 32'hDEAD_BEEF, 32'd1234, 10, 5, -1, "hold5");
    run_op(DIV, 32'hFFFF_0000, 32'd3, 0, 0, 5, "start_busy");

    blocked_start(3'b000, 1'b0, 1'b0, "inv_000");
    blocked_start(3'b101, 1'b0, 1'b0, "inv_101");
    blocked_start(3'b111, 1'b0, 1'b0, "inv_111");
    blocked_start(DIVU, 1'b1, 1'b0, "hold_start");
    blocked_start(DIVU, 1'b0, 1'b1, "flush_start");

    abort_op(1'b0, "flush_step10");
    run_op(DIVU, 32'd100, 32'd7, 0, 0, -1, "after_flush");
    abort_op(1'b1, "rst_step10");
    run_op(REM, 32'hFFFF_FFF9, 32'd2, 0, 0, -1, "after_rst");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 4));
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 1000));
        2:       a = 32'h8000_0000;
        default: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
      endcase
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'd0;
        3:       b = 32'hFFFF_FFFF;
        default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      endcase
      run_op(op, a, b, 0, 0, -1, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
